stream_rr_arbiter: RTL and testbench

STREAM_RR_ARBITER -- requirements
Module: stream_rr_arbiter

---
 rtl/stream_rr_arbiter_pkg.sv | 28 ++
 rtl/stream_rr_pick.sv | 39 +++
 rtl/stream_rr_arbiter.sv | 132 +++++++++++++
 tb/tb_stream_rr_arbiter.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_rr_arbiter_pkg.sv
// ============================================================================
// stream_rr_arbiter_pkg: shared FSM encodings and width helper, rev 1.0
// ============================================================================
`default_nettype none

package stream_rr_arbiter_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    // Index width for n sources; never narrower than one bit.
    function automatic int clog2_min1(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) begin
            w++;
        end
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/stream_rr_pick.sv
// ============================================================================
// stream_rr_pick: rotate-and-priority-encode search starting after ptr, rev 1.0
// ============================================================================
`default_nettype none

module stream_rr_pick
    import stream_rr_arbiter_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int ID_W    = clog2_min1(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic               found,
    output logic [ID_W-1:0]    idx
);

    int              w_cand;
    logic [ID_W-1:0] w_cand_id;

    // Candidates visited in order ptr+1, ptr+2, ... wrapping; the first hit wins.
    always_comb begin
        found     = 1'b0;
        idx       = '0;
        w_cand    = 0;
        w_cand_id = '0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            w_cand    = (int'(ptr) + k) % NUM_SRC;
            w_cand_id = ID_W'(w_cand);
            if (!found && req[w_cand_id]) begin
                found = 1'b1;
                idx   = w_cand_id;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/stream_rr_arbiter.sv
// ============================================================================
// stream_rr_arbiter: packet-locked round-robin AXI-Stream arbiter, rev 1.0
// ============================================================================
`default_nettype none

module stream_rr_arbiter
    import stream_rr_arbiter_pkg::*;
#(
    parameter  int NUM_SRC    = 4,
    parameter  int DATA_WIDTH = 32,
    localparam int ID_W       = clog2_min1(NUM_SRC)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [NUM_SRC-1:0]            s_axis_tvalid,
    input  logic [NUM_SRC-1:0]            s_axis_tlast,
    output logic [NUM_SRC-1:0]            s_axis_tready,
    input  logic [NUM_SRC-1:0]            src_en,
    output logic [DATA_WIDTH-1:0]         m_axis_tdata,
    output logic [ID_W-1:0]               m_axis_tid,
    output logic                          m_axis_tlast,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          busy
);

    localparam logic [ID_W-1:0] c_PTR_RESET = ID_W'(NUM_SRC - 1);

    state_e                state_q, state_d;
    logic [ID_W-1:0]       gnt_q, gnt_d;
    logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [DATA_WIDTH-1:0] tdata_q;
    logic [ID_W-1:0]       tid_q;
    logic                  tlast_q;
    logic                  tvalid_q;

    logic [NUM_SRC-1:0]    w_req;
    logic                  w_pick_found;
    logic [ID_W-1:0]       w_pick_idx;
    logic                  w_src_ready;
    logic                  w_accept;
    logic                  w_sel_last;
    logic [DATA_WIDTH-1:0] w_src_data [NUM_SRC];

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_unpack
        assign w_src_data[i] = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
    end

    // src_en only qualifies new arbitration; an active grant ignores it.
    assign w_req = s_axis_tvalid & src_en;

    stream_rr_pick #(
        .NUM_SRC (NUM_SRC),
        .ID_W    (ID_W)
    ) u_pick (
        .req   (w_req),
        .ptr   (rr_ptr_q),
        .found (w_pick_found),
        .idx   (w_pick_idx)
    );

    assign w_src_ready = (state_q == ST_GRANT) && (!tvalid_q || m_axis_tready);
    assign w_accept    = w_src_ready && s_axis_tvalid[gnt_q];
    assign w_sel_last  = s_axis_tlast[gnt_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            gnt_q    <= '0;
            rr_ptr_q <= c_PTR_RESET;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (w_pick_found) begin
                    gnt_d   = w_pick_idx;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (w_accept && w_sel_last) begin
                    rr_ptr_d = gnt_q;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        s_axis_tready = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            s_axis_tready[i] = w_src_ready && (gnt_q == ID_W'(i));
        end
        busy = (state_q == ST_GRANT);
    end

    // Single-entry output register: reload on accept, otherwise drain on handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tdata_q  <= '0;
            tid_q    <= '0;
            tlast_q  <= 1'b0;
            tvalid_q <= 1'b0;
        end else if (w_accept) begin
            tdata_q  <= w_src_data[gnt_q];
            tid_q    <= gnt_q;
            tlast_q  <= w_sel_last;
            tvalid_q <= 1'b1;
        end else if (tvalid_q && m_axis_tready) begin
            tvalid_q <= 1'b0;
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tid    = tid_q;
    assign m_axis_tlast  = tlast_q;
    assign m_axis_tvalid = tvalid_q;

endmodule

`default_nettype wire

// File: tb/tb_stream_rr_arbiter.sv
// ============================================================================
// tb_stream_rr_arbiter: directed self-checking bench for stream_rr_arbiter, rev 1.0
// ============================================================================
`default_nettype none

module tb_stream_rr_arbiter;

    localparam int NS = 4;
    localparam int DW = 32;
    localparam int IW = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NS*DW-1:0] s_axis_tdata;
    logic [NS-1:0]    s_axis_tvalid;
    logic [NS-1:0]    s_axis_tlast;
    logic [NS-1:0]    s_axis_tready;
    logic [NS-1:0]    src_en;
    logic [DW-1:0]    m_axis_tdata;
    logic [IW-1:0]    m_axis_tid;
    logic             m_axis_tlast;
    logic             m_axis_tvalid;
    logic             m_axis_tready;
    logic             busy;

    always #5 clk = ~clk;

    stream_rr_arbiter #(
        .NUM_SRC    (NS),
        .DATA_WIDTH (DW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .src_en        (src_en),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tid    (m_axis_tid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .busy          (busy)
    );

    int          pkts_left [NS];
    int          plen      [NS];
    int          beat      [NS];
    int          pnum      [NS];
    logic [NS-1:0] hs_s;
    logic [63:0] outq [$];
    int          n_asserts = 0;
    int          n_fail    = 0;

    function automatic logic [31:0] beat_data(input int s, input int p, input int b);
        return {8'hC0 + 8'(s), 8'(p), 16'h1000 + 16'(b)};
    endfunction

    function automatic logic [63:0] exp_beat(input int s, input int p, input int b, input bit last);
        return {22'd0, 2'(s), 7'd0, last, beat_data(s, p, b)};
    endfunction

    function automatic logic [63:0] cur_beat();
        return {22'd0, m_axis_tid, 7'd0, m_axis_tlast, m_axis_tdata};
    endfunction

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_asserts++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Source model: each source streams pkts_left packets of plen beats.
    always_comb begin
        s_axis_tvalid = '0;
        s_axis_tlast  = '0;
        s_axis_tdata  = '0;
        for (int i = 0; i < NS; i++) begin
            s_axis_tvalid[i]         = (pkts_left[i] > 0);
            s_axis_tlast[i]          = (beat[i] == plen[i] - 1);
            s_axis_tdata[i*DW +: DW] = beat_data(i, pnum[i], beat[i]);
        end
    end

    always @(negedge clk) begin
        #3;
        hs_s = s_axis_tvalid & s_axis_tready;
        if (m_axis_tvalid && m_axis_tready) begin
            outq.push_back(cur_beat());
        end
    end

    always @(posedge clk) begin
        #1;
        for (int i = 0; i < NS; i++) begin
            if (hs_s[i]) begin
                beat[i]++;
                if (beat[i] == plen[i]) begin
                    beat[i] = 0;
                    pnum[i]++;
                    pkts_left[i]--;
                end
            end
        end
        hs_s = '0;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_srcs();
        for (int i = 0; i < NS; i++) begin
            pkts_left[i] = 0;
            plen[i]      = 1;
            beat[i]      = 0;
            pnum[i]      = 0;
        end
    endtask

    task automatic do_reset();
        step();
        rst_n = 1'b0;
        clear_srcs();
        outq.delete();
        m_axis_tready = 1'b1;
        src_en = '1;
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic wait_beats(input string tag, input int n, input int budget);
        int cyc;
        cyc = 0;
        while (outq.size() < n && cyc < budget) begin
            step();
            cyc++;
        end
        check_val(tag, outq.size(), n);
    endtask

    function automatic logic [63:0] log_at(input int k);
        return (k < outq.size()) ? outq[k] : '1;
    endfunction

    initial begin
        rst_n = 1'b0;
        m_axis_tready = 1'b1;
        src_en = '1;
        hs_s = '0;
        clear_srcs();
        step();
        step();
        check_val("rst_m_tvalid", m_axis_tvalid, 0);
        check_val("rst_m_tlast", m_axis_tlast, 0);
        check_val("rst_m_tid", m_axis_tid, 0);
        check_val("rst_m_tdata", m_axis_tdata, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_s_tready", s_axis_tready, 0);
        rst_n = 1'b1;
        check_val("post_rst_s_tready", s_axis_tready, 0);
        step();

        // Single source, 3-beat packet with cycle-exact latency.
        pkts_left[0] = 1;
        plen[0]      = 3;
        #1;
        check_val("t1_arb_busy", busy, 0);
        check_val("t1_arb_tready", s_axis_tready, 0);
        step();
        check_val("t1_gnt_busy", busy, 1);
        check_val("t1_gnt_tready", s_axis_tready, 4'b0001);
        check_val("t1_gnt_mvalid", m_axis_tvalid, 0);
        step();
        check_val("t1_beatA_valid", m_axis_tvalid, 1);
        check_val("t1_beatA", cur_beat(), exp_beat(0, 0, 0, 0));
        step();
        check_val("t1_beatB", cur_beat(), exp_beat(0, 0, 1, 0));
        step();
        check_val("t1_beatC", cur_beat(), exp_beat(0, 0, 2, 1));
        check_val("t1_busy_drop", busy, 0);
        step();
        check_val("t1_mvalid_clear", m_axis_tvalid, 0);
        check_val("t1_count", outq.size(), 3);

        // Fairness: four sources, two 2-beat packets each.
        do_reset();
        for (int i = 0; i < NS; i++) begin
            pkts_left[i] = 2;
            plen[i]      = 2;
        end
        wait_beats("t2_count", 16, 100);
        for (int k = 0; k < 16; k++) begin
            check_val($sformatf("t2_beat%0d", k), log_at(k),
                      exp_beat((k / 2) % 4, k / 8, k % 2, (k % 2) == 1));
        end

        // Backpressure mid-packet.
        do_reset();
        pkts_left[0] = 1;
        plen[0]      = 4;
        step();
        step();
        check_val("t3_first", cur_beat(), exp_beat(0, 0, 0, 0));
        m_axis_tready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            check_val($sformatf("t3_hold_data%0d", k), cur_beat(), exp_beat(0, 0, 0, 0));
            check_val($sformatf("t3_hold_valid%0d", k), m_axis_tvalid, 1);
            check_val($sformatf("t3_hold_tready%0d", k), s_axis_tready, 0);
        end
        m_axis_tready = 1'b1;
        wait_beats("t3_count", 4, 50);
        repeat (3) step();
        check_val("t3_no_dup", outq.size(), 4);
        for (int k = 0; k < 4; k++) begin
            check_val($sformatf("t3_beat%0d", k), log_at(k), exp_beat(0, 0, k, k == 3));
        end

        // Enable mask: only sources 1 and 3 may win.
        do_reset();
        src_en = 4'b1010;
        for (int i = 0; i < NS; i++) begin
            pkts_left[i] = 1;
            plen[i]      = 2;
        end
        wait_beats("t4_count", 4, 60);
        check_val("t4_b0", log_at(0), exp_beat(1, 0, 0, 0));
        check_val("t4_b1", log_at(1), exp_beat(1, 0, 1, 1));
        check_val("t4_b2", log_at(2), exp_beat(3, 0, 0, 0));
        check_val("t4_b3", log_at(3), exp_beat(3, 0, 1, 1));
        repeat (5) step();
        check_val("t4_masked_count", outq.size(), 4);
        check_val("t4_masked_busy", busy, 0);
        clear_srcs();
        outq.delete();
        pkts_left[1] = 1;
        plen[1]      = 4;
        step();
        check_val("t4_lock_busy", busy, 1);
        src_en = 4'b1000;
        wait_beats("t4_lock_count", 4, 50);
        for (int k = 0; k < 4; k++) begin
            check_val($sformatf("t4_lock%0d", k), log_at(k), exp_beat(1, 0, k, k == 3));
        end

        // Reset in the middle of a packet from source 2.
        do_reset();
        pkts_left[2] = 1;
        plen[2]      = 4;
        step();
        step();
        check_val("t5_pre_tid", m_axis_tid, 2);
        check_val("t5_pre_valid", m_axis_tvalid, 1);
        rst_n = 1'b0;
        #1;
        check_val("t5_rst_valid", m_axis_tvalid, 0);
        check_val("t5_rst_busy", busy, 0);
        check_val("t5_rst_tready", s_axis_tready, 0);
        clear_srcs();
        outq.delete();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < NS; i++) begin
            pkts_left[i] = 1;
            plen[i]      = 1;
        end
        #1;
        check_val("t5_post_tready", s_axis_tready, 0);
        wait_beats("t5_count", 1, 20);
        check_val("t5_first_src0", log_at(0), exp_beat(0, 0, 0, 1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
